// File: rtl/vending_pkg.sv
// Shared encodings for the parametrised vending controller: FSM states,
// coin codes and the coin-to-rupee conversion.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_INV = 2'b00;
  localparam logic [1:0] COIN_5   = 2'b01;
  localparam logic [1:0] COIN_10  = 2'b10;
  localparam logic [1:0] COIN_20  = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] v;
    case (code)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change payout: one rupee-10 or rupee-5 pulse per cycle while active,
// with the decremented credit and a done flag when the balance hits zero.
module vend_change_dispenser #(
  parameter int CREDIT_W = 6
) (
  input  logic                i_active,
  input  logic [CREDIT_W-1:0] i_credit,
  output logic                o_change_10,
  output logic                o_change_5,
  output logic [CREDIT_W-1:0] o_credit_nxt,
  output logic                o_done
);

  always_comb begin
    o_change_10  = 1'b0;
    o_change_5   = 1'b0;
    o_credit_nxt = i_credit;
    o_done       = 1'b0;
    if (i_active) begin
      if (i_credit >= CREDIT_W'(10)) begin
        o_change_10  = 1'b1;
        o_credit_nxt = i_credit - CREDIT_W'(10);
      end else if (i_credit != '0) begin
        o_change_5   = 1'b1;
        o_credit_nxt = i_credit - CREDIT_W'(5);
      end
      o_done = (o_credit_nxt == '0);
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised coin vending controller with stock tracking, cancel/refund and
// greedy change. Optional idle auto-refund is enabled by VENDING_TIMEOUT_EN.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int CREDIT_W   = 6,
  parameter int INIT_STOCK = 4,
  parameter int STOCK_W    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                busy,
  output logic                vend,
  output logic                change_10,
  output logic                change_5,
  output logic                coin_reject,
  output logic                sold_out
);

  generate
    if (PRICE <= 0 || (PRICE % 5) != 0) begin : g_bad_price
      $error("PRICE must be a nonzero multiple of 5");
    end
    if ((2 ** CREDIT_W) <= PRICE + 15) begin : g_bad_credit_w
      $error("CREDIT_W too narrow for PRICE");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [STOCK_W-1:0]  r_stock;
  logic                r_coin_reject;

  logic                w_sold_out;
  logic                w_can_accept;
  logic                w_accept;
  logic                w_timeout;
  logic [CREDIT_W-1:0] w_coin_sum;
  logic [CREDIT_W-1:0] w_vend_rem;
  logic [CREDIT_W-1:0] w_disp_credit;
  logic                w_disp_done;
  logic                w_change_10;
  logic                w_change_5;

  assign w_sold_out   = (r_stock == '0);
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_accept     = w_can_accept && coin_valid && (coin != COIN_INV) &&
                        !w_sold_out && !cancel && !w_timeout;
  assign w_coin_sum   = r_credit + CREDIT_W'(coin_value(coin));
  assign w_vend_rem   = r_credit - CREDIT_W'(PRICE);

`ifdef VENDING_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_state == ST_COLLECT) && (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Held at zero outside COLLECT, so entering COLLECT always starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_to_cnt <= '0;
    else if (r_state != ST_COLLECT || w_accept) r_to_cnt <= '0;
    else                                     r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  vend_change_dispenser #(.CREDIT_W(CREDIT_W)) u_dispenser (
    .i_active     (r_state == ST_CHANGE),
    .i_credit     (r_credit),
    .o_change_10  (w_change_10),
    .o_change_5   (w_change_5),
    .o_credit_nxt (w_disp_credit),
    .o_done       (w_disp_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nxt = (w_coin_sum >= CREDIT_W'(PRICE)) ? ST_VEND : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (cancel || w_timeout)
          w_state_nxt = ST_CHANGE;
        else if (w_accept)
          w_state_nxt = (w_coin_sum >= CREDIT_W'(PRICE)) ? ST_VEND : ST_COLLECT;
      end
      ST_VEND:   w_state_nxt = (w_vend_rem != '0) ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: if (w_disp_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    vend        = (r_state == ST_VEND);
    busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);
    change_10   = w_change_10;
    change_5    = w_change_5;
    coin_reject = r_coin_reject;
    sold_out    = w_sold_out;
    credit      = r_credit;
    stock       = r_stock;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit      <= '0;
      r_stock       <= STOCK_W'(INIT_STOCK);
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= coin_valid && !w_accept;
      case (r_state)
        ST_IDLE, ST_COLLECT: if (w_accept) r_credit <= w_coin_sum;
        ST_VEND:             r_credit <= w_vend_rem;
        ST_CHANGE:           r_credit <= w_disp_credit;
        default:             r_credit <= r_credit;
      endcase
      if (r_state == ST_VEND && r_stock != '0)
        r_stock <= r_stock - STOCK_W'(1);
      else if (r_state == ST_IDLE && restock)
        r_stock <= STOCK_W'(INIT_STOCK);
    end
  end

endmodule
